// File: rtl/bpu_update_arbiter_pkg.sv
// bpu_update_arbiter_pkg: shared BPU update payload type and arbiter default sizing.
package bpu_update_arbiter_pkg;
   localparam int BPU_UPD_FRONT_DEPTH  = 2;
   localparam int BPU_UPD_STARVE_LIMIT = 4;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
      logic        flush;
      logic        btb_update;
      logic        lpht_update;
      logic        bht_update;
   } bpu_update_t;
endpackage

// File: rtl/bpu_update_arbiter_fifo.sv
// bpu_upd_fifo: power-of-2 FIFO with synchronous clear, occupancy count and full/empty flags.
module bpu_upd_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
      if (push_i) begin
         mem_d[wptr_q] = data_i;
         wptr_d        = wptr_q + 1'b1;
      end
      if (pop_i) rptr_d = rptr_q + 1'b1;
      // clear wins over a same-cycle push or pop
      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end
   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = count_q == CW'(DEPTH);
   assign empty_o = count_q == '0;
endmodule

// File: rtl/bpu_update_arbiter.sv
// bpu_update_arbiter: shares the BPU update port between the backend (priority, lossless) and a
// queued, starvation-protected front fixer. BPU_UPD_PERF_EN adds drop/stall counters.
module bpu_update_arbiter
   import bpu_update_arbiter_pkg::*;
#(
   parameter int FRONT_DEPTH  = BPU_UPD_FRONT_DEPTH,
   parameter int STARVE_LIMIT = BPU_UPD_STARVE_LIMIT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        front_valid_i,
   input  bpu_update_t front_update_i,
   input  logic        back_valid_i,
   input  bpu_update_t back_update_i,
   output logic        back_ready_o,
   input  logic        back_redirect_i,
   output logic        update_valid_o,
   output bpu_update_t update_o,
   input  logic        bpu_ready_i
`ifdef BPU_UPD_PERF_EN
   ,
   output logic [31:0] front_drop_cnt_o,
   output logic [31:0] back_stall_cnt_o
`endif
);
   localparam int CW = $clog2(FRONT_DEPTH) + 1;
   logic          hold_valid_q, hold_valid_d;
   bpu_update_t   hold_q, hold_d;
   logic          update_valid_q, update_valid_d;
   bpu_update_t   update_q, update_d;
   logic [3:0]    starve_q, starve_d;
   logic          free, sel_front, sel_back, hold_pop, front_pop, front_push;
   logic          front_full, front_empty;
   logic [CW-1:0] front_count_unused;
   bpu_update_t   front_head;
   bpu_upd_fifo #(.DEPTH(FRONT_DEPTH), .WIDTH($bits(bpu_update_t))) u_front_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (back_redirect_i),
      .push_i  (front_push),
      .pop_i   (front_pop),
      .data_i  (front_update_i),
      .data_o  (front_head),
      .count_o (front_count_unused),
      .full_o  (front_full),
      .empty_o (front_empty)
   );
   always_comb begin
      free         = !update_valid_q || bpu_ready_i;
      // a redirect purges the queue, so its head must not be granted that cycle
      sel_front    = !front_empty && !back_redirect_i &&
                     (!hold_valid_q || starve_q == 4'(STARVE_LIMIT));
      sel_back     = hold_valid_q && !sel_front;
      hold_pop     = free && sel_back;
      front_pop    = free && sel_front;
      back_ready_o = !hold_valid_q || hold_pop;
      front_push   = front_valid_i && !back_redirect_i && (!front_full || front_pop);
      hold_valid_d = (back_valid_i && back_ready_o) ? 1'b1 : hold_pop ? 1'b0 : hold_valid_q;
      hold_d       = (back_valid_i && back_ready_o) ? back_update_i : hold_q;
      update_valid_d = free ? (sel_front || sel_back) : update_valid_q;
      update_d       = !free ? update_q : sel_front ? front_head : sel_back ? hold_q : update_q;
      starve_d = starve_q;
      if (back_redirect_i || front_empty || front_pop) starve_d = '0;
      else if (hold_pop && starve_q != 4'(STARVE_LIMIT)) starve_d = starve_q + 4'd1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid_q   <= 1'b0;
         hold_q         <= '0;
         update_valid_q <= 1'b0;
         update_q       <= '0;
         starve_q       <= '0;
      end else begin
         hold_valid_q   <= hold_valid_d;
         hold_q         <= hold_d;
         update_valid_q <= update_valid_d;
         update_q       <= update_d;
         starve_q       <= starve_d;
      end
   end
   assign update_valid_o = update_valid_q;
   assign update_o       = update_q;
`ifdef BPU_UPD_PERF_EN
   logic [31:0] drop_q, drop_d, stall_q, stall_d;
   always_comb begin
      drop_d  = (front_valid_i && !front_push && drop_q != '1) ? drop_q + 32'd1 : drop_q;
      stall_d = (back_valid_i && !back_ready_o && stall_q != '1) ? stall_q + 32'd1 : stall_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q  <= '0;
         stall_q <= '0;
      end else begin
         drop_q  <= drop_d;
         stall_q <= stall_d;
      end
   end
   assign front_drop_cnt_o = drop_q;
   assign back_stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_bpu_update_arbiter.sv
// tb_bpu_update_arbiter: directed self-checking bench for bpu_update_arbiter (default sizing).
module tb_bpu_update_arbiter;
   import bpu_update_arbiter_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        front_valid = 1'b0, back_valid = 1'b0, back_redirect = 1'b0, bpu_ready = 1'b0;
   bpu_update_t front_update = '0, back_update = '0, update;
   logic        back_ready, update_valid;
`ifdef BPU_UPD_PERF_EN
   logic [31:0] front_drop_cnt, back_stall_cnt;
`endif
   int errs = 0, checks = 0;
   always #5 clk = ~clk;
   bpu_update_arbiter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .front_valid_i   (front_valid),
      .front_update_i  (front_update),
      .back_valid_i    (back_valid),
      .back_update_i   (back_update),
      .back_ready_o    (back_ready),
      .back_redirect_i (back_redirect),
      .update_valid_o  (update_valid),
      .update_o        (update),
      .bpu_ready_i     (bpu_ready)
`ifdef BPU_UPD_PERF_EN
      ,
      .front_drop_cnt_o (front_drop_cnt),
      .back_stall_cnt_o (back_stall_cnt)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic bpu_update_t mk(input logic [31:0] pc, input logic fl);
      mk            = '0;
      mk.pc         = pc;
      mk.target     = pc + 32'h4;
      mk.flush      = fl;
      mk.btb_update = 1'b1;
      mk.bht_update = !fl;
   endfunction
   logic [31:0] exp3 [7] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h80, 32'h105};
   int k;
   logic br;
   initial begin
      tick();
      chk("rst_valid", 32'(update_valid), 32'd0);
      chk("rst_pc", update.pc, 32'h0);
      chk("rst_back_ready", 32'(back_ready), 32'd1);
      rst_n = 1'b1;
      tick();
      // single back update: two-cycle latency, one beat
      back_valid = 1'b1; back_update = mk(32'h1000, 1'b0); bpu_ready = 1'b1;
      tick();
      chk("t1_early", 32'(update_valid), 32'd0);
      back_valid = 1'b0;
      tick();
      chk("t1_valid", 32'(update_valid), 32'd1);
      chk("t1_pc", update.pc, 32'h1000);
      chk("t1_target", update.target, 32'h1004);
      chk("t1_bht", 32'(update.bht_update), 32'd1);
      tick();
      chk("t1_done", 32'(update_valid), 32'd0);
      // front overflow: output parked on 0xB0 so the queue fills and 0x60 is dropped
      bpu_ready = 1'b0; back_valid = 1'b1; back_update = mk(32'hB0, 1'b0);
      tick();
      back_valid = 1'b0;
      tick();
      chk("t2_park", update.pc, 32'hB0);
      for (int i = 0; i < 3; i++) begin
         front_valid = 1'b1; front_update = mk(32'h20 + 32'(i) * 32'h20, 1'b1);
         tick();
      end
      front_valid = 1'b0;
      tick();
      chk("t2_stable_v", 32'(update_valid), 32'd1);
      chk("t2_stable_pc", update.pc, 32'hB0);
`ifdef BPU_UPD_PERF_EN
      chk("t2_drop_cnt", front_drop_cnt, 32'd1);
`endif
      bpu_ready = 1'b1;
      tick();
      chk("t2_first", update.pc, 32'h20);
      chk("t2_flush", 32'(update.flush), 32'd1);
      tick();
      chk("t2_second", update.pc, 32'h40);
      tick();
      chk("t2_empty", 32'(update_valid), 32'd0);
      // starvation: back stream every cycle, 0x80 forced out after four back wins
      k = 0;
      for (int i = 0; i < 8; i++) begin
         back_valid = 1'b1; back_update = mk(32'h100 + 32'(k), 1'b0);
         front_valid = (i == 1); front_update = mk(32'h80, 1'b1);
         #1 br = back_ready;
         tick();
         if (br) k++;
         if (i >= 1) chk($sformatf("t3_seq%0d", i), update.pc, exp3[i-1]);
      end
      back_valid = 1'b0; front_valid = 1'b0;
      tick(); tick(); tick();
      chk("t3_drained", 32'(update_valid), 32'd0);
      // redirect purges a full queue and masks the same-cycle front input
      bpu_ready = 1'b0; back_valid = 1'b1; back_update = mk(32'hC0, 1'b0);
      tick();
      back_valid = 1'b0;
      tick();
      front_valid = 1'b1; front_update = mk(32'hA0, 1'b1);
      tick();
      front_update = mk(32'hA1, 1'b1);
      tick();
      front_update = mk(32'hA2, 1'b1); back_redirect = 1'b1;
      tick();
      front_valid = 1'b0; back_redirect = 1'b0;
      chk("t4_out_kept", update.pc, 32'hC0);
`ifdef BPU_UPD_PERF_EN
      chk("t4_drop_cnt", front_drop_cnt, 32'd2);
`endif
      bpu_ready = 1'b1;
      tick();
      chk("t4_no_front0", 32'(update_valid), 32'd0);
      tick();
      chk("t4_no_front1", 32'(update_valid), 32'd0);
      // back stall: output and hold both full while the BPU is not ready
      bpu_ready = 1'b0; back_valid = 1'b1; back_update = mk(32'hD0, 1'b0);
      tick();
      back_update = mk(32'hD1, 1'b0);
      tick();
      back_update = mk(32'hD2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t5_ready%0d", i), 32'(back_ready), 32'd0);
         tick();
         chk($sformatf("t5_stable%0d", i), update.pc, 32'hD0);
      end
      back_valid = 1'b0;
`ifdef BPU_UPD_PERF_EN
      chk("t5_stall_cnt", back_stall_cnt, 32'd4);
`endif
      bpu_ready = 1'b1;
      tick();
      chk("t5_hold_out", update.pc, 32'hD1);
      tick();
      chk("t5_done", 32'(update_valid), 32'd0);
      // asynchronous reset mid-operation discards output and queue
      bpu_ready = 1'b0; back_valid = 1'b1; back_update = mk(32'hE0, 1'b0);
      tick();
      back_valid = 1'b0;
      tick();
      front_valid = 1'b1; front_update = mk(32'hE1, 1'b1);
      tick();
      front_valid = 1'b0;
      chk("t6_pre", 32'(update_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("t6_async_valid", 32'(update_valid), 32'd0);
      chk("t6_async_pc", update.pc, 32'h0);
      tick();
      rst_n = 1'b1; bpu_ready = 1'b1;
      tick();
      chk("t6_queue_empty0", 32'(update_valid), 32'd0);
      tick();
      chk("t6_queue_empty1", 32'(update_valid), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/bpu_update_arbiter.md
# bpu_update_arbiter

Shares the single BPU table-update port between two requesters: the decode-stage false-prediction fixer, which drops a bogus taken prediction on a non-branch, and the backend branch-resolution unit. Backend updates are lossless and have priority. Front updates are buffered in a small queue, purged on backend redirect, and protected from starvation. Sits between the front-end/backend and the BTB/LPHT/BHT write logic.

## Interface
- FRONT_DEPTH, 2: front queue entries; power of 2, ≥2.
- STARVE_LIMIT, 4: consecutive back-wins while front is pending before one forced front grant; range 1..15.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- front_valid_i  in  1  front correction present (equals its update.flush).
- front_update_i  in  bpu_update_t  front correction payload.
- back_valid_i  in  1  backend resolution present.
- back_update_i  in  bpu_update_t  backend payload.
- back_ready_o  out  1  back hold register can accept this cycle.
- back_redirect_i  in  1  backend mispredict flush; purges the front queue.
- update_valid_o  out  1  update_o is valid.
- update_o  out  bpu_update_t  registered update to the BPU tables.
- bpu_ready_i  in  1  BPU tables accept update_o this cycle.
- front_drop_cnt_o  out  32  only with BPU_UPD_PERF_EN.
- back_stall_cnt_o  out  32  only with BPU_UPD_PERF_EN.

## Operation
- Back hold: 1-entry register. Captures back_update_i when back_valid_i && back_ready_o. back_ready_o = !hold_valid || hold_pop, where hold_pop means the hold is loaded into the output this cycle. This is a combinational path from bpu_ready_i.
- Front queue: FIFO of FRONT_DEPTH entries.
  - Push when front_valid_i && !back_redirect_i && (count<FRONT_DEPTH || front_pop).
  - Otherwise a valid front input is dropped. Newest is dropped; queued entries are kept.
- Redirect: back_redirect_i clears the queue (count←0) in the same edge. It overrides any same-cycle front push and front pop. It also clears the starve counter. It does not affect the back hold or the output register.
- Output register: "free" = !update_valid_o || bpu_ready_i. When free, it loads the selected source; if neither source is available, update_valid_o←0.
- Selection: back hold is chosen over queue head, except when starve_cnt==STARVE_LIMIT and the queue is non-empty, in which case the queue head is chosen.
- Starve counter (4 bit):
  - Increments when the back hold is chosen while the queue is non-empty.
  - Resets to 0 on any front grant, on an empty queue, or on redirect.
  - Saturates at STARVE_LIMIT.
- Output hold rule: while update_valid_o && !bpu_ready_i, update_o and update_valid_o are stable.
- Payload passes unmodified; the flag fields (btb/lpht/bht_update) come from the requester.

## Timing
- Reset values:
  - update_valid_o=0, update_o='0.
  - back_ready_o=1 (combinational from hold_valid=0).
  - Queue empty, starve_cnt=0, counters=0.
- Latency: input at edge N is captured at N; it appears on update_o after edge N+1 at the earliest (2 cycles input-to-output). There is no bypass.
- Throughput: one update per cycle with bpu_ready_i held high.
- Full queue with same-cycle pop: push accepted.
- Empty queue with same-cycle push: head is not selectable until the next cycle.
- Reset mid-operation: all held and queued updates are discarded immediately.

## Configuration
- BPU_UPD_PERF_EN defined:
  - front_drop_cnt_o counts dropped front inputs, including redirect-masked inputs; it does not count purged entries.
  - back_stall_cnt_o counts cycles with back_valid_i && !back_ready_o.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: both ports and counters are absent; functional behaviour is identical.

## Structure
- The bpu.svh package keeps bpu_update_t. Add BPU_UPD_FRONT_DEPTH and BPU_UPD_STARVE_LIMIT as default constants.
- Sub-module bpu_upd_fifo: parameterised FIFO with synchronous clear, count, full/empty. Used for the front queue.

## Test plan
- Reset, then a single back update (pc=0x1000) with bpu_ready_i=1 → update_valid_o=1 exactly 2 cycles later with pc=0x1000, then 0.
- Front pushes pc=0x20, 0x40, 0x60 on consecutive cycles with bpu_ready_i=0 (FRONT_DEPTH=2) → 0x60 dropped (front_drop_cnt_o=1 with PERF). Release ready → 0x20, then 0x40 in order.
- Back stream every cycle while the front queue holds 0x80, STARVE_LIMIT=4 → four back updates, then 0x80, then back resumes.
- Queue holds 2 entries and back_redirect_i=1 together with front_valid_i → queue empty next cycle; no front update ever reaches update_o.
- bpu_ready_i=0 with output and hold full, back_valid_i=1 for 3 cycles → back_ready_o=0, update_o stable, back_stall_cnt_o=3.
- Assert rst_n low while the queue and output are valid → update_valid_o=0 immediately and the queue is empty after release.
